// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory boot/fetch block.
package riscv_pkg;

    // Instruction word width
    localparam int unsigned ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        LOAD,
        FETCH,
        PRESENT,
        FAULT
    } imem_state_t;

endpackage

// File: rtl/riscv_imem_boot_if.sv
// Boot-loader and PC-facing signals of the instruction memory responder.
interface riscv_imem_boot_if;
    import riscv_pkg::*;

    logic            boot_valid;
    logic [7:0]      boot_byte;
    logic            boot_done;
    logic [31:0]     pc;
    logic [ILEN-1:0] instr;
    logic            instr_valid;
    logic            pc_load;
    logic            ready;
    logic            fault;
    logic            overflow;

    // Boot source / PC side
    modport master (
        output boot_valid, boot_byte, boot_done, pc,
        input  instr, instr_valid, pc_load, ready, fault, overflow
    );

    // Memory responder side
    modport slave (
        input  boot_valid, boot_byte, boot_done, pc,
        output instr, instr_valid, pc_load, ready, fault, overflow
    );

endinterface

// File: rtl/riscv_imem_ram.sv
// Single-port DEPTH x 32 instruction array with a registered read port.
module riscv_imem_ram
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic            re,
    input  logic            clr,
    input  logic [AW-1:0]   addr,
    input  logic [ILEN-1:0] wdata,
    output logic [ILEN-1:0] rdata
);

    logic [ILEN-1:0] mem [DEPTH];

    // Array write; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: NOP after reset or clear, otherwise holds the last word read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= NOP;
        end else if (clr) begin
            rdata <= NOP;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/riscv_imem_boot.sv
// Instruction memory: byte-serial boot loader followed by a two-phase fetch
// responder that paces the PC (one instruction every two cycles).
module riscv_imem_boot
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    riscv_imem_boot_if.slave bus
);

    imem_state_t     state_q, state_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [ILEN-1:0] shift_q, shift_d;
    logic            overflow_q, overflow_d;
    logic            fault_q, fault_d;
    logic            ready_q, ready_d;
    logic            present_q, present_d;

    logic            ram_we;
    logic            ram_re;
    logic            ram_clr;
    logic [AW-1:0]   ram_addr;
    logic [ILEN-1:0] ram_wdata;
    logic [ILEN-1:0] ram_rdata;

    logic            take_byte;
    logic            partial;
    logic            pc_bad;
    logic [ILEN-1:0] word_next;

    // Current word with this cycle's byte merged into its lane
    always_comb begin
        take_byte = bus.boot_valid && !overflow_q;
        word_next = shift_q;
        if (take_byte) begin
            word_next[{byte_cnt_q, 3'b000} +: 8] = bus.boot_byte;
        end
        // Bytes still pending after this cycle's byte is accepted
        partial = take_byte ? (byte_cnt_q != 2'd3) : (byte_cnt_q != 2'd0);
        pc_bad  = (bus.pc[1:0] != 2'b00) || (bus.pc[31:AW+2] != '0);
    end

    // Next-state, boot write and fetch control
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        overflow_d = overflow_q;
        fault_d    = fault_q;
        ready_d    = ready_q;
        present_d  = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_clr    = 1'b0;
        ram_addr   = wr_addr_q;
        ram_wdata  = word_next;

        unique case (state_q)
            LOAD: begin
                if (take_byte) begin
                    if (byte_cnt_q == 2'd3) begin
                        ram_we     = 1'b1;
                        shift_d    = '0;   // keeps upper lanes zero for a later partial flush
                        byte_cnt_d = 2'd0;
                        if (wr_addr_q == AW'(DEPTH - 1)) begin
                            overflow_d = 1'b1;  // last word filled; address does not wrap
                        end else begin
                            wr_addr_d = wr_addr_q + 1'b1;
                        end
                    end else begin
                        shift_d    = word_next;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
                if (bus.boot_done) begin
                    if (partial && !overflow_q) begin
                        ram_we = 1'b1;
                    end
                    state_d = FETCH;
                    ready_d = 1'b1;
                end
            end
            FETCH: begin
                if (pc_bad) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    ram_clr = 1'b1;
                end else begin
                    ram_re    = 1'b1;
                    ram_addr  = bus.pc[AW+1:2];
                    present_d = 1'b1;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                state_d = FETCH;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LOAD;
            wr_addr_q  <= '0;
            byte_cnt_q <= 2'd0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
            fault_q    <= 1'b0;
            ready_q    <= 1'b0;
            present_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
            fault_q    <= fault_d;
            ready_q    <= ready_d;
            present_q  <= present_d;
        end
    end

    riscv_imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .clr   (ram_clr),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.instr       = ram_rdata;
    assign bus.instr_valid = present_q;
    assign bus.pc_load     = present_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_riscv_imem_boot.sv
// Bench for riscv_imem_boot: two instances (DEPTH 256 and DEPTH 4) share the boot
// stream; a byte-count / cycle-parity model predicts every output on every cycle.
module tb_riscv_imem_boot;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        boot_valid = 1'b0;
    logic [7:0]  boot_byte = 8'h00;
    logic        boot_done = 1'b0;
    logic [31:0] pc_b = 32'h0;
    logic [31:0] pc_s = 32'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_imem_boot_if if_b ();
    riscv_imem_boot_if if_s ();

    assign if_b.boot_valid = boot_valid;
    assign if_b.boot_byte  = boot_byte;
    assign if_b.boot_done  = boot_done;
    assign if_b.pc         = pc_b;
    assign if_s.boot_valid = boot_valid;
    assign if_s.boot_byte  = boot_byte;
    assign if_s.boot_done  = boot_done;
    assign if_s.pc         = pc_s;

    riscv_imem_boot #(.DEPTH(256), .AW(8)) dut_big (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    riscv_imem_boot #(.DEPTH(4), .AW(2)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (if_s.slave)
    );

    function void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int          depth [2] = '{256, 4};
    int          mode [2];      // 0 booting, 1 running, 2 faulted
    int          run_cyc [2];   // cycles since boot finished; even ones sample pc
    int          nbytes [2];    // image bytes accepted since reset
    logic [31:0] pend [2];
    bit          m_ovf [2], m_rdy [2], m_flt [2], m_vld [2], m_known_ins [2];
    logic [31:0] m_ins [2];
    logic [31:0] m_mem [2][256];
    bit          m_known [2][256];

    function void model_reset(int d);
        mode[d] = 0; run_cyc[d] = 0; nbytes[d] = 0; pend[d] = 32'h0;
        m_ovf[d] = 0; m_rdy[d] = 0; m_flt[d] = 0; m_vld[d] = 0;
        m_ins[d] = NOP; m_known_ins[d] = 1;
    endfunction

    function void model_step(int d);
        logic [31:0] p;
        int w;
        p = (d == 0) ? pc_b : pc_s;
        if (mode[d] == 0) begin
            if (boot_valid && nbytes[d] < 4 * depth[d]) begin
                pend[d][8 * (nbytes[d] % 4) +: 8] = boot_byte;
                nbytes[d]++;
                if (nbytes[d] % 4 == 0) begin
                    w = nbytes[d] / 4 - 1;
                    m_mem[d][w] = pend[d]; m_known[d][w] = 1; pend[d] = 32'h0;
                end
                if (nbytes[d] == 4 * depth[d]) m_ovf[d] = 1;
            end
            if (boot_done) begin
                if (nbytes[d] % 4 != 0) begin
                    w = nbytes[d] / 4;
                    m_mem[d][w] = pend[d]; m_known[d][w] = 1;
                end
                mode[d] = 1; m_rdy[d] = 1; run_cyc[d] = 0;
            end
        end else if (mode[d] == 1) begin
            if (run_cyc[d] % 2 == 0) begin
                if (p % 4 != 0 || p >= 32'(4 * depth[d])) begin
                    mode[d] = 2; m_flt[d] = 1; m_vld[d] = 0;
                    m_ins[d] = NOP; m_known_ins[d] = 1;
                end else begin
                    m_vld[d] = 1;
                    m_ins[d] = m_mem[d][p / 4];
                    m_known_ins[d] = m_known[d][p / 4];
                end
            end else begin
                m_vld[d] = 0;
            end
            run_cyc[d]++;
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) model_reset(d);
            else model_step(d);
        end
    end

    function void cmp(int d, logic [31:0] ins, logic v, logic pl, logic r, logic f, logic o);
        check($sformatf("d%0d instr_valid", d), 32'(v), 32'(m_vld[d]));
        check($sformatf("d%0d pc_load", d), 32'(pl), 32'(m_vld[d]));
        check($sformatf("d%0d ready", d), 32'(r), 32'(m_rdy[d]));
        check($sformatf("d%0d fault", d), 32'(f), 32'(m_flt[d]));
        check($sformatf("d%0d overflow", d), 32'(o), 32'(m_ovf[d]));
        if (m_known_ins[d]) check($sformatf("d%0d instr", d), ins, m_ins[d]);
    endfunction

    // Compare both instances against the model away from the active edge
    always @(negedge clk) begin
        cmp(0, if_b.instr, if_b.instr_valid, if_b.pc_load, if_b.ready, if_b.fault, if_b.overflow);
        cmp(1, if_s.instr, if_s.instr_valid, if_s.pc_load, if_s.ready, if_s.fault, if_s.overflow);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input bit done);
        boot_valid = 1'b1; boot_byte = b; boot_done = done;
        step();
        boot_valid = 1'b0; boot_done = 1'b0;
    endtask

    task automatic pulse_done();
        boot_done = 1'b1;
        step();
        boot_done = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] p);
        pc_b = p; pc_s = p;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_pc(int dep, bit allow_bad);
        if (allow_bad && $urandom_range(0, 31) == 0) begin
            if ($urandom_range(0, 1) == 0) return 32'(4 * $urandom_range(0, dep - 1) + $urandom_range(1, 3));
            return 32'(4 * dep) + 32'(4 * $urandom_range(0, 1000));
        end
        if ($urandom_range(0, 1) == 0) return 32'(4 * $urandom_range(0, (dep < 8 ? dep : 8) - 1));
        return 32'(4 * $urandom_range(0, dep - 1));
    endfunction

    logic [7:0]  boot_img [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [31:0] ovf_words [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};

    initial begin
        int len;
        bit fr;
        // Reset values
        step(); step();
        #1;
        check("rst instr", if_b.instr, NOP);
        check("rst instr_valid", 32'(if_b.instr_valid), 32'h0);
        check("rst pc_load", 32'(if_b.pc_load), 32'h0);
        check("rst ready", 32'(if_b.ready), 32'h0);
        check("rst fault", 32'(if_b.fault), 32'h0);
        check("rst overflow", 32'(if_b.overflow), 32'h0);
        step();
        rst = 1'b1;

        // Two-word boot image, then run from pc 0 and 4
        foreach (boot_img[i]) send(boot_img[i], 1'b0);
        #1 check("ready before done", 32'(if_b.ready), 32'h0);
        pulse_done();
        #1 check("ready after done", 32'(if_b.ready), 32'h1);
        set_pc(32'h0);
        step();
        #1 check("word0 valid", 32'(if_b.instr_valid), 32'h1);
        check("word0 pc_load", 32'(if_b.pc_load), 32'h1);
        check("word0 instr", if_b.instr, 32'h00000013);
        set_pc(32'h4);
        step();
        #1 check("gap valid", 32'(if_b.instr_valid), 32'h0);
        check("gap instr hold", if_b.instr, 32'h00000013);
        step();
        #1 check("word1 instr", if_b.instr, 32'h00100093);
        check("word1 small instr", if_s.instr, 32'h00100093);
        step();

        // Misaligned pc faults and stays faulted
        set_pc(32'h6);
        step();
        #1 check("misalign fault", 32'(if_b.fault), 32'h1);
        check("fault instr", if_b.instr, NOP);
        set_pc(32'h0);
        repeat (6) step();
        #1 check("fault held", 32'(if_b.fault), 32'h1);
        check("fault no valid", 32'(if_b.instr_valid), 32'h0);

        // Async reset mid-run takes effect immediately
        rst = 1'b0;
        #1 check("rst clears fault", 32'(if_b.fault), 32'h0);
        check("rst clears ready", 32'(if_b.ready), 32'h0);
        check("rst instr nop", if_b.instr, NOP);
        step();
        rst = 1'b1;

        // Partial word with done on the last byte
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
        #1 check("partial ready", 32'(if_b.ready), 32'h1);
        step();
        #1 check("partial word", if_b.instr, 32'h00CCBBAA);
        check("partial word small", if_s.instr, 32'h00CCBBAA);
        set_pc(32'h3FC);
        step(); step();
        #1 check("last word no fault", 32'(if_b.fault), 32'h0);
        check("last word valid", 32'(if_b.instr_valid), 32'h1);
        set_pc(32'h400);
        step(); step();
        #1 check("range fault", 32'(if_b.fault), 32'h1);
        reset_pulse();

        // Overflow on the small instance
        set_pc(32'h0);
        for (int i = 0; i < 20; i++) begin
            send(8'h10 + 8'(i), 1'b0);
            if (i == 14) #1 check("no overflow at 15", 32'(if_s.overflow), 32'h0);
            if (i == 15) #1 check("overflow at 16", 32'(if_s.overflow), 32'h1);
        end
        check("big no overflow", 32'(if_b.overflow), 32'h0);
        pulse_done();
        step();
        #1 check("ovf word0", if_s.instr, ovf_words[0]);
        for (int k = 1; k < 4; k++) begin
            set_pc(32'(4 * k));
            step(); step();
            #1 check($sformatf("ovf word%0d", k), if_s.instr, ovf_words[k]);
        end

        // Reset during the second word restarts at address 0
        reset_pulse();
        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i), 1'b0);
        send(8'h60, 1'b0); send(8'h61, 1'b0);
        rst = 1'b0;
        #1 check("mid-boot rst overflow", 32'(if_s.overflow), 32'h0);
        check("mid-boot rst ready", 32'(if_s.ready), 32'h0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), i == 3);
        set_pc(32'h0);
        step();
        #1 check("reboot word0", if_s.instr, 32'h43424140);
        set_pc(32'h4);
        step(); step();
        #1 check("reboot word1 kept", if_s.instr, 32'h17161514);

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            reset_pulse();
            len = $urandom_range(0, 24);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 40) == 0) reset_pulse();
                repeat ($urandom_range(0, 2)) step();
                send(8'($urandom), (i == len - 1) && ($urandom_range(0, 1) == 1));
            end
            if (!(if_b.ready === 1'b1)) pulse_done();
            fr = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < int'($urandom_range(10, 60)); c++) begin
                pc_b = rand_pc(256, fr);
                pc_s = rand_pc(4, fr);
                boot_valid = 1'($urandom);
                boot_byte = 8'($urandom);
                boot_done = 1'($urandom);
                step();
            end
            boot_valid = 1'b0;
            boot_done = 1'b0;
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_imem_boot.md
Name: riscv_imem_boot

Overview:
Instruction-memory responder for the RISC-V program counter. It receives the PC address and returns the instruction word, and it drives the PC's load/advance enable. Before execution, a byte-serial boot loader fills the memory array. The block then switches to a two-phase fetch responder that paces the PC.

Parameters:
DEPTH, 256, number of 32-bit instruction words in the array
AW, 8, word-address width; must equal clog2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
boot_valid  input  1  boot_byte is valid this cycle
boot_byte  input  8  program byte, little-endian order within each word
boot_done  input  1  end of program image (single-cycle pulse)
pc  input  32  byte address from the PC register
instr  output  32  fetched instruction
instr_valid  output  1  instr is valid this cycle
pc_load  output  1  advance enable for the PC (drives its load input)
ready  output  1  boot complete; fetch engine running
fault  output  1  sticky: misaligned or out-of-range PC
overflow  output  1  sticky: boot image larger than DEPTH words

Behaviour:
- Reset (rst=0, async): state=LOAD, wr_addr=0, byte_cnt=0, shift register=0.
  - Outputs: instr=32'h00000013 (NOP), instr_valid=0, pc_load=0, ready=0, fault=0, overflow=0.
  - The array is not cleared. A reset mid-boot or mid-run returns to LOAD.
- States: LOAD -> FETCH <-> PRESENT, and FETCH -> FAULT. FAULT exits only by reset.
- LOAD:
  - On boot_valid, place boot_byte into byte lane byte_cnt and increment byte_cnt (mod 4).
  - On the 4th byte, write the word to mem[wr_addr] in the same cycle and increment wr_addr.
  - After word DEPTH-1 has been written: set overflow and ignore further bytes. wr_addr does not wrap.
  - On boot_done, any partial word is zero-padded in the upper lanes and written at wr_addr (if not overflowed). The next state is FETCH and ready=1 from that next cycle.
  - boot_valid and boot_done in the same cycle: the byte is accepted first, then the flush happens.
  - boot_done with byte_cnt=0: no write.
- FETCH:
  - If pc[1:0]!=0 or pc[31:AW+2]!=0: next state FAULT.
  - Otherwise issue a synchronous read of mem[pc[AW+1:2]]. Next state PRESENT.
  - instr_valid=0 and pc_load=0 in this state.
- PRESENT:
  - instr = read data. instr_valid=1 and pc_load=1 for exactly this cycle.
  - The PC updates on the same clock edge. Next state FETCH.
  - Throughput: one instruction per 2 cycles.
  - Latency: pc sampled at the FETCH edge; instr valid one cycle later.
- FAULT: fault=1, instr=NOP, instr_valid=0, pc_load=0. Held until reset.
- instr holds its last value when instr_valid=0; it is NOP after reset.
- boot_valid and boot_done are ignored outside LOAD.
- pc is ignored in LOAD.
- All outputs are registered.

Decomposition:
- Shared package riscv_pkg:
  - NOP constant 32'h00000013
  - imem state enum {LOAD, FETCH, PRESENT, FAULT}
  - instruction word width 32
- One sub-module, riscv_imem_ram:
  - single-port, DEPTH x 32, synchronous read, write-enable
  - no reset on the array

Test Plan:
- Reset: assert rst=0 mid-cycle -> all outputs at reset values immediately (instr=0x00000013, others 0).
- Boot 8 bytes 13 00 00 00 93 00 10 00, then boot_done -> mem[0]=0x00000013, mem[1]=0x00100093. ready=1 on the cycle after boot_done.
- Run with pc=0, then 4 after the PC updates -> instr_valid high on alternate cycles with pc_load coincident. instr sequence 0x00000013, then 0x00100093.
- Partial word: bytes AA BB CC with boot_done on the same cycle as CC -> word 0x00CCBBAA stored at the current wr_addr, then ready=1.
- Fault: pc=0x00000006 in FETCH -> fault=1 next cycle, instr_valid and pc_load stay 0 indefinitely. With DEPTH=256, pc=0x00000400 also faults. rst clears fault.
- Overflow: DEPTH=4, send 20 bytes -> overflow=1 after the 16th byte and mem[0..3] unchanged by the extra bytes. Pulse rst during the 2nd word -> state LOAD, wr_addr=0, overflow=0.
